arp_lookup: RTL and testbench

ARP_LOOKUP -- requirements
Module: arp_lookup

---
 rtl/arp_lookup.sv | 160 ++++++++++++++++
 tb/tb_arp_lookup.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/arp_lookup.sv
// rtl/arp_lookup.sv - ARP table lookup with CRC-16 hashing and linear probing; `ARP_LOOKUP_STATS_EN adds hit/miss counters
// Table entries are {valid, ip[31:0], mac[47:0]}; the hash must match the table writer's.

module arp_crc16 #(
    parameter int OUT_W = 10
) (
    input  logic [31:0]      data,
    output logic [OUT_W-1:0] crc
);
    logic [15:0] c;

    // Reflected CRC-16 (poly 0x8408), zero init, LSB of data first, no final XOR.
    always_comb begin
        c = '0;
        for (int i = 0; i < 32; i++) begin
            if (c[0] ^ data[i]) c = {1'b0, c[15:1]} ^ 16'h8408;
            else                c = {1'b0, c[15:1]};
        end
    end

    assign crc = c[OUT_W-1:0];
endmodule

module arp_lookup #(
    parameter int MAX_PROBE = 4,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [31:0]       req_ip,
    output logic              req_ready,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [80:0]       ram_rd_data,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [47:0]       rsp_mac,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int PW = 5;

    typedef enum logic [1:0] {IDLE, RD, CMP, RSP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       ip_q;
    logic [ADDR_W-1:0] index_q;
    logic [PW-1:0]     probe_q;
    logic [ADDR_W-1:0] hash;
    logic              accept, advance, done, hit;
    logic              entry_valid;
    logic [31:0]       entry_ip;
    logic [47:0]       entry_mac;

    assign entry_valid = ram_rd_data[80];
    assign entry_ip    = ram_rd_data[79:48];
    assign entry_mac   = ram_rd_data[47:0];

    arp_crc16 #(.OUT_W(ADDR_W)) u_hash (
        .data (req_ip),
        .crc  (hash)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        ram_rd_en = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        done      = 1'b0;
        hit       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                ram_rd_en = 1'b1;
                state_d   = CMP;
            end
            CMP: begin
                // An empty slot ends the probe chain: the writer never skips over holes.
                if (!entry_valid) begin
                    done = 1'b1;
                end else if (entry_ip == ip_q) begin
                    done = 1'b1;
                    hit  = 1'b1;
                end else if (probe_q < PW'(MAX_PROBE)) begin
                    advance = 1'b1;
                end else begin
                    done = 1'b1;
                end
                if (done)         state_d = RSP;
                else if (advance) state_d = RD;
            end
            RSP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip_q     <= '0;
            index_q  <= '0;
            probe_q  <= '0;
            rsp_hit  <= 1'b0;
            rsp_mac  <= '0;
            rsp_addr <= '0;
        end else begin
            if (accept) begin
                ip_q    <= req_ip;
                index_q <= hash;
                probe_q <= '0;
            end
            if (ram_rd_en) probe_q <= probe_q + PW'(1);
            if (advance)   index_q <= index_q + ADDR_W'(1);
            if (done) begin
                rsp_hit  <= hit;
                rsp_mac  <= hit ? entry_mac : 48'h0;
                rsp_addr <= index_q;
            end
        end
    end

    assign ram_addr = index_q;

`ifdef ARP_LOOKUP_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (done) begin
            if (hit && hit_cnt_q != 16'hFFFF)    hit_cnt_q  <= hit_cnt_q + 16'd1;
            if (!hit && miss_cnt_q != 16'hFFFF)  miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 16'h0;
    assign miss_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_arp_lookup.sv
// tb/tb_arp_lookup.sv - directed and random lookups against a table/hash reference model
module tb_arp_lookup;
    localparam int MAX_PROBE = 4;
    localparam int ADDR_W    = 10;
    localparam int SLOTS     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic [31:0]       req_ip = '0;
    logic              req_ready;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [80:0]       ram_rd_data = '0;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [47:0]       rsp_mac;
    logic [ADDR_W-1:0] rsp_addr;
    logic [15:0]       hit_cnt, miss_cnt;

    logic [80:0] mem [SLOTS];
    int checks = 0;
    int fails = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    arp_lookup #(.MAX_PROBE(MAX_PROBE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ip(req_ip),
        .req_ready(req_ready), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
        .ram_rd_data(ram_rd_data), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .rsp_mac(rsp_mac), .rsp_addr(rsp_addr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_hash(input logic [31:0] ip);
        logic [15:0] c = 16'h0;
        for (int i = 0; i < 32; i++)
            c = (c[0] ^ ip[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return int'(c) % SLOTS;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < SLOTS; i++) mem[i] = '0;
    endtask

    function automatic logic [31:0] other_ip(input logic [31:0] ip);
        return ip ^ (32'h1 << $urandom_range(31, 0));
    endfunction

    task automatic expect_counts();
`ifdef ARP_LOOKUP_STATS_EN
        chk("hit_cnt", hit_cnt, exp_hits);
        chk("miss_cnt", miss_cnt, exp_misses);
`else
        chk("hit_cnt_off", hit_cnt, 0);
        chk("miss_cnt_off", miss_cnt, 0);
`endif
    endtask

    task automatic lookup(input logic [31:0] ip);
        int          h, nreads, k;
        bit          ehit, got;
        logic [47:0] emac;
        int          eaddr;
        logic [80:0] e;
        int          addrs[$];
        int          seen[$];
        h = model_hash(ip);
        ehit = 0; emac = '0; nreads = 0; eaddr = h;
        for (int p = 0; p < MAX_PROBE; p++) begin
            eaddr = (h + p) % SLOTS;
            addrs.push_back(eaddr);
            nreads++;
            e = mem[eaddr];
            if (!e[80]) break;
            if (e[79:48] == ip) begin ehit = 1; emac = e[47:0]; break; end
        end
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_ip    = ip;
        @(posedge clk);
        got = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_ip = $urandom;
            if (ram_rd_en) seen.push_back(int'(ram_addr));
            if (rsp_valid) begin got = 1; break; end
        end
        req_valid = 1'b0;
        chk("rsp_seen", got, 1);
        chk("latency", k, 1 + 2 * nreads);
        chk("rsp_hit", rsp_hit, ehit);
        chk("rsp_mac", rsp_mac, emac);
        chk("rsp_addr", rsp_addr, eaddr);
        chk("read_count", seen.size(), nreads);
        for (int i = 0; i < seen.size() && i < addrs.size(); i++)
            chk("ram_addr_seq", seen[i], addrs[i]);
        if (ehit) exp_hits++; else exp_misses++;
        expect_counts();
        @(negedge clk);
        chk("rsp_pulse_one_cycle", rsp_valid, 0);
        chk("rsp_hit_hold", rsp_hit, ehit);
        chk("rsp_mac_hold", rsp_mac, emac);
        chk("rsp_addr_hold", rsp_addr, eaddr);
    endtask

    initial begin
        logic [31:0] ip, ip2;
        logic [31:0] pool[$];
        int h, s;
        bit quiet;

        clear_mem();
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_ram_rd_en", ram_rd_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_mac", rsp_mac, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Zero address hashes to slot 0, direct hit.
        chk("hash_zero", model_hash(32'h0), 0);
        mem[0] = {1'b1, 32'h0, 48'h001122334455};
        lookup(32'h0);

        // Collision at H, match at H+1.
        clear_mem();
        ip = $urandom;
        h = model_hash(ip);
        mem[h] = {1'b1, other_ip(ip), 48'($urandom)};
        mem[(h + 1) % SLOTS] = {1'b1, ip, 16'($urandom), 32'($urandom)};
        lookup(ip);

        // Start at the last slot and wrap to slot 0.
        clear_mem();
        ip = $urandom;
        for (int i = 0; i < 60000 && model_hash(ip) != SLOTS - 1; i++) ip = ip + 1;
        chk("found_wrap_ip", model_hash(ip), SLOTS - 1);
        mem[SLOTS - 1] = {1'b1, other_ip(ip), 48'hABCDEF012345};
        mem[0] = {1'b1, ip, 48'h0A0B0C0D0E0F};
        lookup(ip);

        // Probe limit reached, then empty-slot miss.
        clear_mem();
        ip = $urandom;
        h = model_hash(ip);
        for (int p = 0; p < MAX_PROBE + 1; p++)
            mem[(h + p) % SLOTS] = {1'b1, other_ip(ip), 48'($urandom)};
        mem[(h + MAX_PROBE) % SLOTS] = {1'b1, ip, 48'h123456789ABC};
        lookup(ip);
        clear_mem();
        lookup(ip);

        // Reset while the first probe is being compared.
        ip = $urandom;
        mem[model_hash(ip)] = {1'b1, ip, 48'hFEDCBA987654};
        @(negedge clk);
        req_valid = 1'b1;
        req_ip    = ip;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        exp_hits = 0;
        exp_misses = 0;
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_ram_rd_en", ram_rd_en, 0);
        chk("mid_rst_ram_addr", ram_addr, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_hit", rsp_hit, 0);
        chk("mid_rst_rsp_mac", rsp_mac, 0);
        chk("mid_rst_rsp_addr", rsp_addr, 0);
        expect_counts();
        @(negedge clk);
        reset = 1'b0;
        quiet = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) quiet = 0;
        end
        chk("no_rsp_after_reset", quiet, 1);
        lookup(ip);

        // Counter scenario: three hits and two misses since reset.
        lookup(ip);
        lookup(ip);
        ip2 = other_ip(ip);
        if (model_hash(ip2) == model_hash(ip)) ip2 = ~ip;
        mem[model_hash(ip2)] = '0;
        lookup(ip2);
        lookup(ip2);
        expect_counts();

        // Random table filled by a linear-probing writer, mixed hit/miss lookups.
        clear_mem();
        for (int n = 0; n < 300; n++) begin
            ip = $urandom;
            s = model_hash(ip);
            for (int p = 0; p < SLOTS && mem[s][80]; p++) s = (s + 1) % SLOTS;
            mem[s] = {1'b1, ip, 16'($urandom), 32'($urandom)};
            pool.push_back(ip);
        end
        for (int n = 0; n < 24; n++) begin
            if (n % 2 == 0) lookup(pool[$urandom_range(pool.size() - 1, 0)]);
            else            lookup($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
